vga_sync_gen: RTL and testbench

Generates VGA 640x480@60 timing directly in the 100 MHz domain. It uses an internal divide-by-DIV pixel strobe, so no derived pixel clock is needed. It produces hsync, vsync, display-enable and pixel coordinates, each qualified by a one-cycle pixel strobe, for the pattern and framebuffer logic that drives the VGA pads.

---
 rtl/vga_sync_gen.sv | 90 +++++++++
 tb/tb_vga_sync_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA sync/timing generator in the 100 MHz domain using a divide-by-DIV pixel strobe
module vga_sync_gen #(
  parameter int DIV      = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk_100m,
  input  logic       btn_rst,
  input  logic       en,
  output logic       pix_stb,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [3:0] DIV_LAST = 4'(DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam int HS_BEGIN = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEGIN = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [3:0] div_cnt;
  logic       advance;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  int         xi;
  int         yi;

  assign advance = en && (div_cnt == DIV_LAST);

  // Decode is taken from the coordinate being entered, so outputs line up with the new x/y.
  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (x == X_LAST) begin
      x_nxt = '0;
      y_nxt = (y == Y_LAST) ? 10'd0 : y + 10'd1;
    end else begin
      x_nxt = x + 10'd1;
    end
    xi = int'(x_nxt);
    yi = int'(y_nxt);
  end

  always_ff @(posedge clk_100m or posedge btn_rst) begin
    if (btn_rst) begin
      div_cnt     <= '0;
      x           <= X_LAST;
      y           <= Y_LAST;
      hsync       <= !SYNC_POL;
      vsync       <= !SYNC_POL;
      de          <= 1'b0;
      pix_stb     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_stb     <= advance;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (en) begin
        div_cnt <= advance ? 4'd0 : div_cnt + 4'd1;
      end
      if (advance) begin
        x           <= x_nxt;
        y           <= y_nxt;
        hsync       <= ((xi >= HS_BEGIN) && (xi < HS_END)) ? SYNC_POL : !SYNC_POL;
        vsync       <= ((yi >= VS_BEGIN) && (yi < VS_END)) ? SYNC_POL : !SYNC_POL;
        de          <= (xi < H_ACTIVE) && (yi < V_ACTIVE);
        line_start  <= (x_nxt == 10'd0);
        frame_start <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - randomized bench for vga_sync_gen against a pixel-index reference model
module tb_vga_sync_gen;

  // geometry: DIV, H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP
  localparam int GA [9] = '{3, 20, 3, 5, 4, 10, 2, 2, 3};
  localparam int GB [9] = '{2, 16, 2, 4, 2, 8, 1, 2, 2};

  typedef struct packed {
    logic       stb;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  logic clk_100m = 1'b0;
  logic btn_rst;
  logic en;
  exp_t oa;
  exp_t ob;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_a = 0;
  int   n_b = 0;

  always #5 clk_100m = ~clk_100m;

  vga_sync_gen #(
    .DIV(GA[0]), .H_ACTIVE(GA[1]), .H_FP(GA[2]), .H_SYNC(GA[3]), .H_BP(GA[4]),
    .V_ACTIVE(GA[5]), .V_FP(GA[6]), .V_SYNC(GA[7]), .V_BP(GA[8]), .SYNC_POL(1'b0)
  ) dut_a (
    .clk_100m(clk_100m), .btn_rst(btn_rst), .en(en),
    .pix_stb(oa.stb), .hsync(oa.hs), .vsync(oa.vs), .de(oa.de),
    .x(oa.x), .y(oa.y), .line_start(oa.ls), .frame_start(oa.fs)
  );

  vga_sync_gen #(
    .DIV(GB[0]), .H_ACTIVE(GB[1]), .H_FP(GB[2]), .H_SYNC(GB[3]), .H_BP(GB[4]),
    .V_ACTIVE(GB[5]), .V_FP(GB[6]), .V_SYNC(GB[7]), .V_BP(GB[8]), .SYNC_POL(1'b1)
  ) dut_b (
    .clk_100m(clk_100m), .btn_rst(btn_rst), .en(en),
    .pix_stb(ob.stb), .hsync(ob.hs), .vsync(ob.vs), .de(ob.de),
    .x(ob.x), .y(ob.y), .line_start(ob.ls), .frame_start(ob.fs)
  );

  // n = enabled edges since reset; the k-th pixel strobe lands on pixel index k-1 of the frame
  function automatic exp_t model(input int n, input bit en_edge, input int g [9], input bit pol);
    exp_t e;
    int div, ht, vt, k, idx, px, py;
    div = g[0];
    ht  = g[1] + g[2] + g[3] + g[4];
    vt  = g[5] + g[6] + g[7] + g[8];
    k   = n / div;
    e.stb = en_edge && (n > 0) && (n % div == 0);
    if (k == 0) begin
      px = ht - 1;
      py = vt - 1;
      e.hs = !pol;
      e.vs = !pol;
      e.de = 1'b0;
    end else begin
      idx  = (k - 1) % (ht * vt);
      px   = idx % ht;
      py   = idx / ht;
      e.hs = (px >= g[1] + g[2] && px < g[1] + g[2] + g[3]) ? pol : !pol;
      e.vs = (py >= g[5] + g[6] && py < g[5] + g[6] + g[7]) ? pol : !pol;
      e.de = (px < g[1]) && (py < g[5]);
    end
    e.x  = 10'(px);
    e.y  = 10'(py);
    e.ls = e.stb && (px == 0);
    e.fs = e.stb && (px == 0) && (py == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_one(input string nm, input exp_t got, input exp_t e);
    chk({nm, ".pix_stb"}, 32'(got.stb), 32'(e.stb));
    chk({nm, ".hsync"}, 32'(got.hs), 32'(e.hs));
    chk({nm, ".vsync"}, 32'(got.vs), 32'(e.vs));
    chk({nm, ".de"}, 32'(got.de), 32'(e.de));
    chk({nm, ".line_start"}, 32'(got.ls), 32'(e.ls));
    chk({nm, ".frame_start"}, 32'(got.fs), 32'(e.fs));
    chk({nm, ".x"}, 32'(got.x), 32'(e.x));
    chk({nm, ".y"}, 32'(got.y), 32'(e.y));
  endtask

  task automatic chk_all(input bit en_edge);
    chk_one("a", oa, model(n_a, en_edge, GA, 1'b0));
    chk_one("b", ob, model(n_b, en_edge, GB, 1'b1));
  endtask

  initial begin
    int last_fs_a, last_fs_b, off_run, rst_pending;
    btn_rst = 1'b1;
    en = 1'b0;
    repeat (3) @(posedge clk_100m);
    #1 chk_all(1'b0);
    last_fs_a = -1;
    last_fs_b = -1;
    off_run = 0;
    rst_pending = 0;

    // phase 1: continuous enable over several frames, frame period checked directly
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk_100m);
      btn_rst = 1'b0;
      en = 1'b1;
      @(posedge clk_100m);
      n_a++;
      n_b++;
      #1 chk_all(1'b1);
      if (oa.fs) begin
        if (last_fs_a >= 0) chk("a.frame_period", 32'(cyc - last_fs_a), 32'(32 * 17 * GA[0]));
        else chk("a.first_frame_edge", 32'(cyc + 1), 32'(GA[0]));
        last_fs_a = cyc;
      end
      if (ob.fs) begin
        if (last_fs_b >= 0) chk("b.frame_period", 32'(cyc - last_fs_b), 32'(24 * 13 * GB[0]));
        last_fs_b = cyc;
      end
    end

    // phase 2: random enable gaps and asynchronous mid-cycle resets
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk_100m);
      if (rst_pending != 0) begin
        btn_rst = 1'b0;
        rst_pending = 0;
      end
      if (off_run > 0) begin
        off_run--;
        en = 1'b0;
      end else if ($urandom_range(0, 15) == 0) begin
        off_run = $urandom_range(0, 40);
        en = 1'b0;
      end else begin
        en = 1'b1;
      end
      @(posedge clk_100m);
      if (en) begin
        n_a++;
        n_b++;
      end
      #1 chk_all(en);
      if ((cyc % 1700) == 850) begin
        #2 btn_rst = 1'b1;
        #1 n_a = 0;
        n_b = 0;
        chk_all(1'b0);
        @(posedge clk_100m);
        #1 chk_all(1'b0);
        rst_pending = 1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
